gsensor_spi_reader: RTL and testbench

GSENSOR_SPI_READER -- requirements
Module: gsensor_spi_reader

---
 rtl/gsensor_pkg.sv | 39 +++
 rtl/spi_mode3_xfer.sv | 111 +++++++++++
 rtl/gsensor_spi_reader.sv | 147 ++++++++++++++
 tb/tb_gsensor_spi_reader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/gsensor_pkg.sv
// Shared constants for the ADXL345 G-sensor reader: register map, config
// values, command bit positions and FSM state encodings.
package gsensor_pkg;

  localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
  localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
  localparam logic [7:0] REG_DATAX0      = 8'h32;

  localparam logic [7:0] CFG_DATA_FORMAT = 8'h00;
  localparam logic [7:0] CFG_POWER_CTL   = 8'h08;

  localparam int unsigned CMD_RW_BIT = 7;
  localparam int unsigned CMD_MB_BIT = 6;

  typedef enum logic [2:0] {
    INIT_FMT,
    INIT_PWR,
    WAIT,
    READ,
    GAP
  } gsensor_state_e;

  typedef enum logic [1:0] {
    X_IDLE,
    X_LEAD,
    X_LOW,
    X_HIGH
  } xfer_state_e;

  function automatic logic [7:0] spi_cmd(input logic rd, input logic mb,
                                         input logic [7:0] addr);
    logic [7:0] c;
    c             = addr;
    c[CMD_RW_BIT] = rd;
    c[CMD_MB_BIT] = mb;
    return c;
  endfunction

endpackage

// File: rtl/spi_mode3_xfer.sv
// One SPI mode-3 transaction of up to 24 bits, MSB first, tx word left-aligned.
// done_o is high in the final cycle, so the rx word is complete as CS_n rises.
module spi_mode3_xfer
  import gsensor_pkg::*;
#(
  parameter int unsigned SCLK_HALF = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [4:0]  nbits_i,
  input  logic [23:0] tx_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [23:0] rx_o,
  output logic        cs_n_o,
  output logic        sclk_o,
  output logic        mosi_o,
  input  logic        miso_i
);

  xfer_state_e st_q;
  logic [7:0]  hcnt_q;
  logic [4:0]  bit_q;
  logic [4:0]  nbits_q;
  logic [23:0] tx_q;
  logic [23:0] rx_q;
  logic        cs_n_q;
  logic        sclk_q;
  logic        mosi_q;
  logic        half_end;
  logic        last_bit;

  assign half_end = (hcnt_q == 8'(SCLK_HALF - 1));
  assign last_bit = (bit_q == nbits_q);

  assign busy_o = (st_q != X_IDLE);
  assign done_o = (st_q == X_HIGH) && half_end && last_bit;
  assign rx_o   = rx_q;
  assign cs_n_o = cs_n_q;
  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= X_IDLE;
      hcnt_q  <= '0;
      bit_q   <= '0;
      nbits_q <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      unique case (st_q)
        X_IDLE: begin
          if (start_i) begin
            tx_q    <= tx_i;
            nbits_q <= nbits_i;
            bit_q   <= '0;
            hcnt_q  <= '0;
            rx_q    <= '0;
            cs_n_q  <= 1'b0;
            mosi_q  <= tx_i[23];
            st_q    <= X_LEAD;
          end
        end
        X_LEAD: begin
          if (half_end) begin
            hcnt_q <= '0;
            sclk_q <= 1'b0;
            st_q   <= X_LOW;
          end else begin
            hcnt_q <= hcnt_q + 8'd1;
          end
        end
        X_LOW: begin
          if (half_end) begin
            hcnt_q <= '0;
            sclk_q <= 1'b1;
            rx_q   <= {rx_q[22:0], miso_i};
            bit_q  <= bit_q + 5'd1;
            st_q   <= X_HIGH;
          end else begin
            hcnt_q <= hcnt_q + 8'd1;
          end
        end
        X_HIGH: begin
          if (half_end) begin
            hcnt_q <= '0;
            if (last_bit) begin
              cs_n_q <= 1'b1;
              st_q   <= X_IDLE;
            end else begin
              // First bit was presented at CS_n assertion; later bits shift out here.
              sclk_q <= 1'b0;
              mosi_q <= tx_q[22];
              tx_q   <= {tx_q[22:0], 1'b0};
              st_q   <= X_LOW;
            end
          end else begin
            hcnt_q <= hcnt_q + 8'd1;
          end
        end
        default: st_q <= X_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/gsensor_spi_reader.sv
// ADXL345 reader: configures the sensor once, then polls the X axis every
// SAMPLE_PERIOD clocks and presents a 10-bit two's complement sample.
module gsensor_spi_reader
  import gsensor_pkg::*;
#(
  parameter int unsigned SCLK_HALF     = 25,
  parameter int unsigned SAMPLE_PERIOD = 500000
) (
  input  logic       clk,
  input  logic       reset,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic [9:0] accel_data,
  output logic       data_valid,
  output logic       init_done
);

  localparam int unsigned GAP_CYC = 2 * SCLK_HALF;
  localparam int unsigned GW      = $clog2(GAP_CYC);
  localparam int unsigned PW      = $clog2(SAMPLE_PERIOD);

  gsensor_state_e st_q;
  logic           launched_q;
  logic           start_q;
  logic           first_q;
  logic [GW-1:0]  gap_q;
  logic [PW-1:0]  per_q;
  logic [9:0]     accel_q;
  logic           valid_q;
  logic           init_q;

  logic           x_busy;
  logic           x_done;
  logic [23:0]    x_rx;
  logic [23:0]    tx_w;
  logic [4:0]     nbits_w;
  logic           gap_ok;
  logic           per_ok;
  logic           read_go;
  logic           unused_rx;

  assign gap_ok    = (gap_q == GW'(GAP_CYC - 1));
  assign per_ok    = (per_q == PW'(SAMPLE_PERIOD - 1));
  assign read_go   = gap_ok && (((st_q == GAP) && (first_q || per_ok)) ||
                                ((st_q == WAIT) && per_ok));
  assign unused_rx = ^{x_rx[23:16], x_rx[7:2]};

  assign accel_data = accel_q;
  assign data_valid = valid_q;
  assign init_done  = init_q;

  always_comb begin
    tx_w    = {spi_cmd(1'b1, 1'b1, REG_DATAX0), 16'h0000};
    nbits_w = 5'd24;
    unique case (st_q)
      INIT_FMT: begin
        tx_w    = {spi_cmd(1'b0, 1'b0, REG_DATA_FORMAT), CFG_DATA_FORMAT, 8'h00};
        nbits_w = 5'd16;
      end
      INIT_PWR: begin
        tx_w    = {spi_cmd(1'b0, 1'b0, REG_POWER_CTL), CFG_POWER_CTL, 8'h00};
        nbits_w = 5'd16;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q       <= INIT_FMT;
      launched_q <= 1'b0;
      start_q    <= 1'b0;
      first_q    <= 1'b1;
      gap_q      <= '0;
      per_q      <= '0;
      accel_q    <= '0;
      valid_q    <= 1'b0;
      init_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      valid_q <= 1'b0;
      // Gap only accumulates while CS_n is high, including the cycles after reset.
      if (!x_busy && !start_q && !gap_ok) gap_q <= gap_q + 1'b1;
      if (!per_ok) per_q <= per_q + 1'b1;

      unique case (st_q)
        INIT_FMT, INIT_PWR: begin
          if (!launched_q) begin
            if (gap_ok) begin
              start_q    <= 1'b1;
              launched_q <= 1'b1;
              gap_q      <= '0;
            end
          end else if (x_done) begin
            launched_q <= 1'b0;
            if (st_q == INIT_PWR) begin
              init_q <= 1'b1;
              st_q   <= GAP;
            end else begin
              st_q <= INIT_PWR;
            end
          end
        end
        READ: begin
          if (x_done) begin
            accel_q <= {x_rx[1:0], x_rx[15:8]};
            valid_q <= 1'b1;
            st_q    <= GAP;
          end
        end
        GAP: begin
          if (gap_ok && !first_q && !per_ok) st_q <= WAIT;
        end
        WAIT: ;
        default: st_q <= INIT_FMT;
      endcase

      if (read_go) begin
        start_q <= 1'b1;
        gap_q   <= '0;
        per_q   <= '0;
        first_q <= 1'b0;
        st_q    <= READ;
      end
    end
  end

  spi_mode3_xfer #(
    .SCLK_HALF(SCLK_HALF)
  ) u_xfer (
    .clk     (clk),
    .reset   (reset),
    .start_i (start_q),
    .nbits_i (nbits_w),
    .tx_i    (tx_w),
    .busy_o  (x_busy),
    .done_o  (x_done),
    .rx_o    (x_rx),
    .cs_n_o  (spi_cs_n),
    .sclk_o  (spi_sclk),
    .mosi_o  (spi_mosi),
    .miso_i  (spi_miso)
  );

endmodule

// File: tb/tb_gsensor_spi_reader.sv
// Directed bench for gsensor_spi_reader with a behavioural ADXL345 slave
// (SCLK_HALF=4, SAMPLE_PERIOD=400).
module tb_gsensor_spi_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_cs_n, spi_sclk, spi_mosi;
  logic       spi_miso;
  logic [9:0] accel_data;
  logic       data_valid, init_done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          bits;
    logic [23:0] word;
    int          fall;
    int          hi;
    logic        dv;
    logic [9:0]  acc;
    logic        ini;
  } txn_t;

  txn_t        txq[$];
  int          cyc = 0;
  int          last_evt = 0;
  int          last_rise = 0;
  int          fall_cyc = 0;
  int          hi_before = 0;
  int          mon_bits = 0;
  int          fidx = 0;
  int          ph_min = 1000000;
  int          ph_max = 0;
  int          dv_count = 0;
  logic [23:0] mon_word = '0;
  logic        in_read = 1'b0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b1;
  logic        miso_r = 1'b0;
  logic        noise_en = 1'b0;
  logic [7:0]  x0 = 8'hA5;
  logic [7:0]  x1 = 8'hFE;

  assign spi_miso = miso_r;

  always #5 clk = ~clk;

  gsensor_spi_reader #(
    .SCLK_HALF(4),
    .SAMPLE_PERIOD(400)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .spi_cs_n   (spi_cs_n),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .accel_data (accel_data),
    .data_valid (data_valid),
    .init_done  (init_done)
  );

  // Slave and bus monitor, sampled on the falling clk edge.
  always @(negedge clk) begin
    logic [23:0] resp;
    int          len;
    txn_t        t;
    cyc  = cyc + 1;
    resp = {8'h5A, x0, x1};
    if (reset === 1'b1) begin
      last_rise = cyc;
      mon_bits  = 0;
      mon_word  = '0;
      in_read   = 1'b0;
    end else begin
      if (spi_cs_n === 1'b0 && prev_cs === 1'b1) begin
        fall_cyc  = cyc;
        hi_before = cyc - last_rise;
        last_evt  = cyc;
        mon_bits  = 0;
        mon_word  = '0;
        fidx      = 0;
        in_read   = (init_done === 1'b1);
      end else if (spi_cs_n === 1'b0 && spi_sclk !== prev_sclk) begin
        len = cyc - last_evt;
        if (len < ph_min) ph_min = len;
        if (len > ph_max) ph_max = len;
        last_evt = cyc;
        if (spi_sclk === 1'b1) begin
          mon_word = {mon_word[22:0], spi_mosi};
          mon_bits = mon_bits + 1;
        end else begin
          if (fidx < 24) miso_r = resp[23 - fidx];
          fidx = fidx + 1;
        end
      end else if (spi_cs_n === 1'b1 && prev_cs === 1'b0) begin
        len = cyc - last_evt;
        if (len < ph_min) ph_min = len;
        if (len > ph_max) ph_max = len;
        last_rise = cyc;
        t.bits = mon_bits;
        t.word = mon_word;
        t.fall = fall_cyc;
        t.hi   = hi_before;
        t.dv   = data_valid;
        t.acc  = accel_data;
        t.ini  = init_done;
        txq.push_back(t);
        in_read = 1'b0;
      end
      if (spi_cs_n === 1'b1 && noise_en) miso_r = ~miso_r;
      if (data_valid === 1'b1) dv_count = dv_count + 1;
    end
    prev_cs   = spi_cs_n;
    prev_sclk = spi_sclk;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_txn(input int n, input string what);
    int b = 0;
    while (txq.size() < n && b < 3000) begin
      tick();
      b++;
    end
    if (txq.size() < n) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: saw %0d transactions, required %0d", what, txq.size(), n);
    end
  endtask

  task automatic test_reset();
    repeat (5) tick();
    tests++; if (spi_cs_n !== 1'b1) begin fails++; $display("FAIL rst_cs_n: got %b, expected 1", spi_cs_n); end
    tests++; if (spi_sclk !== 1'b1) begin fails++; $display("FAIL rst_sclk: got %b, expected 1", spi_sclk); end
    tests++; if (spi_mosi !== 1'b0) begin fails++; $display("FAIL rst_mosi: got %b, expected 0", spi_mosi); end
    tests++; if (accel_data !== 10'h000) begin fails++; $display("FAIL rst_accel: got %h, expected 000", accel_data); end
    tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b, expected 0", data_valid); end
    tests++; if (init_done !== 1'b0) begin fails++; $display("FAIL rst_init_done: got %b, expected 0", init_done); end
    reset = 1'b0;
  endtask

  task automatic test_init_writes(input string tag);
    wait_txn(2, {tag, "_init"});
    tests++; if (txq[0].bits !== 16) begin fails++; $display("FAIL %s_fmt_bits: got %0d, expected 16", tag, txq[0].bits); end
    tests++; if (txq[0].word[15:0] !== 16'h3100) begin fails++; $display("FAIL %s_fmt_word: got %h, expected 3100", tag, txq[0].word[15:0]); end
    tests++; if (txq[0].ini !== 1'b0) begin fails++; $display("FAIL %s_init_early: got %b, expected 0", tag, txq[0].ini); end
    tests++; if (txq[0].hi < 8) begin fails++; $display("FAIL %s_release_gap: got %0d cycles, expected >= 8", tag, txq[0].hi); end
    tests++; if (txq[1].bits !== 16) begin fails++; $display("FAIL %s_pwr_bits: got %0d, expected 16", tag, txq[1].bits); end
    tests++; if (txq[1].word[15:0] !== 16'h2D08) begin fails++; $display("FAIL %s_pwr_word: got %h, expected 2d08", tag, txq[1].word[15:0]); end
    tests++; if (txq[1].ini !== 1'b1) begin fails++; $display("FAIL %s_init_done: got %b, expected 1", tag, txq[1].ini); end
    tests++; if (txq[1].hi < 8) begin fails++; $display("FAIL %s_cs_gap: got %0d cycles, expected >= 8", tag, txq[1].hi); end
    tests++; if (ph_min !== 4 || ph_max !== 4) begin fails++; $display("FAIL %s_sclk_phase: got min %0d max %0d, expected 4", tag, ph_min, ph_max); end
  endtask

  task automatic test_read_basic();
    wait_txn(3, "read_basic");
    x0 = 8'h1F;
    x1 = 8'h00;
    tests++; if (txq[2].bits !== 24) begin fails++; $display("FAIL read_bits: got %0d, expected 24", txq[2].bits); end
    tests++; if (txq[2].word !== 24'hF20000) begin fails++; $display("FAIL read_cmd: got %h, expected f20000", txq[2].word); end
    tests++; if (txq[2].acc !== 10'h2A5) begin fails++; $display("FAIL read_accel_at_rise: got %h, expected 2a5", txq[2].acc); end
    tests++; if (txq[2].dv !== 1'b1) begin fails++; $display("FAIL read_valid_at_rise: got %b, expected 1", txq[2].dv); end
    tests++; if (txq[2].hi < 8) begin fails++; $display("FAIL read_gap: got %0d cycles, expected >= 8", txq[2].hi); end
    tick();
    tests++; if (dv_count !== 1) begin fails++; $display("FAIL read_valid_pulses: got %0d, expected 1", dv_count); end
    tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL read_valid_width: got %b, expected 0", data_valid); end
  endtask

  task automatic test_period();
    wait_txn(5, "period");
    tests++; if (txq[4].fall - txq[3].fall !== 400) begin fails++; $display("FAIL period_spacing: got %0d, expected 400", txq[4].fall - txq[3].fall); end
    tests++; if (txq[3].fall - txq[2].fall !== 400) begin fails++; $display("FAIL period_spacing0: got %0d, expected 400", txq[3].fall - txq[2].fall); end
    tests++; if (txq[3].acc !== 10'h01F || txq[4].acc !== 10'h01F) begin fails++; $display("FAIL period_accel: got %h/%h, expected 01f", txq[3].acc, txq[4].acc); end
    repeat (100) tick();
    tests++; if (accel_data !== 10'h01F) begin fails++; $display("FAIL period_hold: got %h, expected 01f", accel_data); end
    tests++; if (dv_count !== 3) begin fails++; $display("FAIL period_valid_pulses: got %0d, expected 3", dv_count); end
  endtask

  task automatic test_reset_mid_read();
    int b = 0;
    while (!(in_read && mon_bits == 13) && b < 1000) begin
      tick();
      b++;
    end
    tests++; if (!(in_read && mon_bits == 13)) begin fails++; $display("FAIL midrst_reach_bit13: got %0d bits, expected 13", mon_bits); end
    reset = 1'b1;
    #1;
    tests++; if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b1) begin fails++; $display("FAIL midrst_pins: got cs %b sclk %b, expected 1 1", spi_cs_n, spi_sclk); end
    tests++; if (accel_data !== 10'h000) begin fails++; $display("FAIL midrst_accel: got %h, expected 000", accel_data); end
    tests++; if (init_done !== 1'b0 || data_valid !== 1'b0) begin fails++; $display("FAIL midrst_flags: got init %b valid %b, expected 0 0", init_done, data_valid); end
    x0       = 8'h00;
    x1       = 8'hFF;
    noise_en = 1'b1;
    repeat (3) tick();
    txq.delete();
    dv_count = 0;
    ph_min   = 1000000;
    ph_max   = 0;
    reset    = 1'b0;
    test_init_writes("reinit");
    tests++; if (dv_count !== 0 || accel_data !== 10'h000) begin fails++; $display("FAIL midrst_no_update: got %0d pulses accel %h, expected 0 000", dv_count, accel_data); end
  endtask

  task automatic test_noise_upper();
    wait_txn(3, "noise_a");
    x1 = 8'hFC;
    tests++; if (txq[2].acc !== 10'h300) begin fails++; $display("FAIL noise_ff: got %h, expected 300", txq[2].acc); end
    wait_txn(4, "noise_b");
    x0 = 8'h80;
    x1 = 8'h7D;
    tests++; if (txq[3].acc !== 10'h000) begin fails++; $display("FAIL noise_fc: got %h, expected 000", txq[3].acc); end
    wait_txn(5, "noise_c");
    tests++; if (txq[4].acc !== 10'h180) begin fails++; $display("FAIL noise_7d: got %h, expected 180", txq[4].acc); end
    tests++; if (dv_count !== 3) begin fails++; $display("FAIL noise_valid_pulses: got %0d, expected 3", dv_count); end
    tests++; if (ph_min !== 4 || ph_max !== 4) begin fails++; $display("FAIL noise_sclk_phase: got min %0d max %0d, expected 4", ph_min, ph_max); end
  endtask

  initial begin
    test_reset();
    test_init_writes("boot");
    test_read_basic();
    test_period();
    test_reset_mid_read();
    test_noise_upper();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
